// File: rtl/wt_dcache_mem_arbiter_pkg.sv
// rtl/wt_dcache_mem_arbiter_pkg.sv - shared sizes, request/response types and free-TID helper
package wt_dcache_mem_arbiter_pkg;

  localparam int unsigned NumPortsDef    = 3;
  localparam int unsigned MemTidWidthDef = 2;
  localparam int unsigned AddrWidthDef   = 64;
  localparam int unsigned DataWidthDef   = 64;
  localparam int unsigned MaxTids        = 2 ** MemTidWidthDef;

  typedef struct packed {
    logic [AddrWidthDef-1:0]   addr;
    logic                      we;
    logic [DataWidthDef-1:0]   wdata;
    logic [DataWidthDef/8-1:0] be;
    logic [MemTidWidthDef-1:0] tid;
  } mem_req_t;

  typedef struct packed {
    logic [MemTidWidthDef-1:0] tid;
    logic [DataWidthDef-1:0]   rdata;
  } mem_rsp_t;

  // Index of the lowest clear bit among the first n bits; 0 when none is clear.
  function automatic int unsigned lowest_zero(input logic [31:0] vec, input int unsigned n);
    int unsigned res;
    res = 0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(n) && !vec[5'(i)]) res = unsigned'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/wt_dcache_mem_arbiter_if.sv
// rtl/wt_dcache_mem_arbiter_if.sv - requester, memory request and memory response bundle
interface wt_dcache_mem_arbiter_if
  import wt_dcache_mem_arbiter_pkg::*;
#(
  parameter int unsigned NumPorts    = NumPortsDef,
  parameter int unsigned MemTidWidth = MemTidWidthDef,
  parameter int unsigned AddrWidth   = AddrWidthDef,
  parameter int unsigned DataWidth   = DataWidthDef
) ();

  logic [NumPorts-1:0]             req_valid_i;
  logic [NumPorts-1:0]             req_ready_o;
  logic [NumPorts*AddrWidth-1:0]   req_addr_i;
  logic [NumPorts-1:0]             req_we_i;
  logic [NumPorts*DataWidth-1:0]   req_wdata_i;
  logic [NumPorts*DataWidth/8-1:0] req_be_i;

  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [AddrWidth-1:0]   mem_req_addr_o;
  logic                   mem_req_we_o;
  logic [DataWidth-1:0]   mem_req_wdata_o;
  logic [DataWidth/8-1:0] mem_req_be_o;
  logic [MemTidWidth-1:0] mem_req_tid_o;

  logic                   mem_rsp_valid_i;
  logic [MemTidWidth-1:0] mem_rsp_tid_i;
  logic [DataWidth-1:0]   mem_rsp_rdata_i;

  logic [NumPorts-1:0]    rsp_valid_o;
  logic [DataWidth-1:0]   rsp_rdata_o;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_be_o,
    output mem_req_tid_o,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    output rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_be_o,
    input  mem_req_tid_o,
    output mem_req_ready_i,
    output mem_rsp_valid_i, mem_rsp_tid_i, mem_rsp_rdata_i,
    input  rsp_valid_o, rsp_rdata_o
  );

endinterface

// File: rtl/wt_dcache_mem_arbiter_rr_arb_onehot.sv
// rtl/wt_dcache_mem_arbiter_rr_arb_onehot.sv - round-robin one-hot arbiter, pointer moves to the winner on grant
module rr_arb_onehot #(
  parameter int unsigned N        = 3,
  parameter int unsigned IdxWidth = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        req_i,
  input  logic                en_i,
  output logic [N-1:0]        gnt_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] cand;
  logic                found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    // Highest priority goes to the port just after the last winner.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxWidth'((32'(ptr_q) + k) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (en_i && found) begin
      gnt_o[idx_o] = 1'b1;
      ptr_d        = idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= IdxWidth'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wt_dcache_mem_arbiter.sv
// rtl/wt_dcache_mem_arbiter.sv - shares one memory request channel between dcache ports, routes responses by TID
module wt_dcache_mem_arbiter
  import wt_dcache_mem_arbiter_pkg::*;
#(
  parameter int unsigned NumPorts    = NumPortsDef,
  parameter int unsigned MemTidWidth = MemTidWidthDef,
  parameter int unsigned AddrWidth   = AddrWidthDef,
  parameter int unsigned DataWidth   = DataWidthDef
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  wt_dcache_mem_arbiter_if.master        bus,
  input  logic                           quiesce_i,
  output logic                           idle_o,
  output logic                           spurious_rsp_o
);

  localparam int unsigned NumTids  = 2 ** MemTidWidth;
  localparam int unsigned IdxWidth = $clog2(NumPorts);
  localparam int unsigned BeWidth  = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth-1:0]   wdata;
    logic [BeWidth-1:0]     be;
    logic [MemTidWidth-1:0] tid;
  } out_req_t;

  out_req_t            out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [NumTids-1:0]  tid_busy_q, tid_busy_d;
  logic [IdxWidth-1:0] tid_owner_q [NumTids];
  logic [IdxWidth-1:0] tid_owner_d [NumTids];

  logic [AddrWidth-1:0] port_addr  [NumPorts];
  logic [DataWidth-1:0] port_wdata [NumPorts];
  logic [BeWidth-1:0]   port_be    [NumPorts];

  logic                   drain;
  logic                   tid_avail;
  logic                   grant_en;
  logic                   grant;
  logic [MemTidWidth-1:0] free_tid;
  logic [NumPorts-1:0]    gnt;
  logic [IdxWidth-1:0]    gnt_idx;
  logic                   rsp_hit;
  logic [NumPorts-1:0]    rsp_valid;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign port_addr[p]  = bus.req_addr_i[p*AddrWidth +: AddrWidth];
    assign port_wdata[p] = bus.req_wdata_i[p*DataWidth +: DataWidth];
    assign port_be[p]    = bus.req_be_i[p*BeWidth +: BeWidth];
  end

  // A slot opens when the register is empty or hands its request over this cycle.
  assign drain     = out_valid_q & bus.mem_req_ready_i;
  assign tid_avail = ~&tid_busy_q;
  assign grant_en  = ~rst_i & ~quiesce_i & tid_avail & (~out_valid_q | drain);
  assign grant     = |gnt;
  assign free_tid  = MemTidWidth'(lowest_zero(32'(tid_busy_q), NumTids));

  rr_arb_onehot #(
    .N (NumPorts)
  ) u_rr_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.req_valid_i),
    .en_i  (grant_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign bus.req_ready_o = gnt;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_d.addr  = port_addr[gnt_idx];
      out_d.we    = bus.req_we_i[gnt_idx];
      out_d.wdata = port_wdata[gnt_idx];
      out_d.be    = port_be[gnt_idx];
      out_d.tid   = free_tid;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  assign rsp_hit        = ~rst_i & bus.mem_rsp_valid_i & tid_busy_q[bus.mem_rsp_tid_i];
  assign spurious_rsp_o = ~rst_i & bus.mem_rsp_valid_i & ~tid_busy_q[bus.mem_rsp_tid_i];

  always_comb begin
    rsp_valid = '0;
    if (rsp_hit) rsp_valid[tid_owner_q[bus.mem_rsp_tid_i]] = 1'b1;
  end

  // A freed TID only becomes allocatable next cycle because free_tid looks at the registered state.
  always_comb begin
    tid_busy_d  = tid_busy_q;
    tid_owner_d = tid_owner_q;
    if (rsp_hit) tid_busy_d[bus.mem_rsp_tid_i] = 1'b0;
    if (grant) begin
      tid_busy_d[free_tid]  = 1'b1;
      tid_owner_d[free_tid] = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      tid_busy_q  <= '0;
      tid_owner_q <= '{default: '0};
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      tid_busy_q  <= tid_busy_d;
      tid_owner_q <= tid_owner_d;
    end
  end

  assign bus.mem_req_valid_o = out_valid_q;
  assign bus.mem_req_addr_o  = out_q.addr;
  assign bus.mem_req_we_o    = out_q.we;
  assign bus.mem_req_wdata_o = out_q.wdata;
  assign bus.mem_req_be_o    = out_q.be;
  assign bus.mem_req_tid_o   = out_q.tid;
  assign bus.rsp_valid_o     = rsp_valid;
  assign bus.rsp_rdata_o     = bus.mem_rsp_rdata_i;
  assign idle_o              = ~|tid_busy_q & ~out_valid_q;

endmodule

// File: doc/wt_dcache_mem_arbiter.md
Name: wt_dcache_mem_arbiter

Overview:
Round-robin arbiter that shares the write-through data cache's single memory request channel between NumPorts requesters (miss unit, write buffer, AMO unit). It allocates a transaction ID (TID) per accepted request and holds a TID-to-port table. Memory responses are routed back to the issuing port by TID. It sits between the dcache ports and the memory/NoC adapter, and provides a quiesce/idle handshake for fence sequencing.

Parameters:
NumPorts, 3, number of requesters (2..8)
MemTidWidth, 2, TID width; MaxTids = 2**MemTidWidth outstanding transactions
AddrWidth, 64, request address width
DataWidth, 64, write/read data width (equals AXI data width)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  NumPorts  per-port request valid
req_ready_o  out  NumPorts  per-port request accepted (one-hot or zero)
req_addr_i  in  NumPorts*AddrWidth  per-port address
req_we_i  in  NumPorts  per-port write enable
req_wdata_i  in  NumPorts*DataWidth  per-port write data
req_be_i  in  NumPorts*DataWidth/8  per-port byte enables
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  AddrWidth  granted address
mem_req_we_o  out  1  granted write enable
mem_req_wdata_o  out  DataWidth  granted write data
mem_req_be_o  out  DataWidth/8  granted byte enables
mem_req_tid_o  out  MemTidWidth  allocated TID
mem_rsp_valid_i  in  1  memory response valid (always accepted)
mem_rsp_tid_i  in  MemTidWidth  response TID
mem_rsp_rdata_i  in  DataWidth  response data
rsp_valid_o  out  NumPorts  routed response valid (one-hot or zero)
rsp_rdata_o  out  DataWidth  response data, broadcast to all ports
quiesce_i  in  1  stop granting new requests
idle_o  out  1  no TID outstanding and output register empty
spurious_rsp_o  out  1  one-cycle pulse on a response to an unallocated TID

Behaviour:
- Reset: rr pointer = NumPorts-1, output register empty, all TIDs free, table cleared. All outputs 0 except idle_o = 1.
- Output stage is a one-entry register. mem_req_valid_o comes straight from the register. Payload and TID stay stable while valid && !ready.
- Grant condition (cycle N): any req_valid_i, !quiesce_i, at least one free TID, and the output register is empty or draining in cycle N (mem_req_valid_o && mem_req_ready_i).
- On grant:
  - req_ready_o is high for the winner only.
  - The payload plus the lowest-index free TID load into the register. mem_req_valid_o rises at N+1 (1-cycle latency).
  - The TID is marked busy and table[tid] = winner index.
- Arbitration: round-robin. Search starts at ptr+1 modulo NumPorts. ptr = winner on grant only; with no grant, ptr is unchanged.
- req_ready_o is combinational from req_valid_i. Requesters must hold valid and payload until ready.
- Response:
  - When mem_rsp_valid_i is high and TID t is busy, rsp_valid_o[table[t]] = 1 in the same cycle and rsp_rdata_o = mem_rsp_rdata_i.
  - t is freed at the clock edge. It is usable for allocation from the next cycle, not the same cycle.
- If TID t is free when its response arrives: rsp_valid_o stays 0, spurious_rsp_o pulses, and no state changes.
- TID exhaustion: with all MaxTids busy, no grant (req_ready_o = 0) until a response frees one.
- quiesce_i: blocks new grants only. A loaded output register still drains, and responses still route.
- idle_o = no TID busy && output register empty. It is combinational from state.
- Reset asserted mid-operation: all state clears immediately and in-flight TIDs are forgotten. Later responses with those TIDs flag spurious_rsp_o.

Decomposition:
- Shared package: request and response structs sized by the parameters, plus the MaxTids constant.
- Sub-module rr_arb_onehot (round-robin arbiter with pointer update on grant).
- The TID free-list and table live in the top module.

Test Plan:
- Reset -> idle_o = 1; mem_req_valid_o, rsp_valid_o, req_ready_o and spurious_rsp_o all 0; ptr = 2.
- Port1 alone requests addr 0x8000_0040, we = 0 at cycle 5 -> req_ready_o = 3'b010 at 5; mem_req_valid_o = 1 at 6 with addr 0x8000_0040, tid 0; idle_o = 0.
- Ports 0, 1, 2 all hold valid, mem_req_ready_i = 1 -> grants in order 0, 1, 2, 0 on consecutive cycles with TIDs 0, 1, 2, 3; the fifth grant stalls.
- Four TIDs busy, a response arrives for tid 2 carrying 0xDEAD_BEEF -> rsp_valid_o to port 2 same cycle with that data; the next grant occurs the following cycle with tid 2.
- mem_req_ready_i held low for 4 cycles -> mem_req_valid_o, addr and tid stable all 4 cycles; no further grant until the register drains.
- quiesce_i = 1 with one request pending and tid 0 outstanding -> no grant; the response for tid 0 routes and idle_o rises the next cycle. A response for tid 3 (free) -> spurious_rsp_o pulses and rsp_valid_o = 0.
